// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported synchronous RAM between instruction fetch,
// data loads and data stores. Stores complete in the grant cycle. A read holds
// the port for MEM_LATENCY cycles and then returns its data as a one-cycle pulse.
module mem_port_arbiter #(
   parameter int unsigned ADDR_BITS   = 14,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned STARVE_MAX  = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   // fetch read port
   input  logic                 f_req_i,
   input  logic [31:0]          f_addr_i,
   input  logic                 f_kill_i,
   output logic                 f_gnt_o,
   output logic                 f_rvalid_o,
   output logic [31:0]          f_rdata_o,
   // load read port
   input  logic                 dr_req_i,
   input  logic [31:0]          dr_addr_i,
   output logic                 dr_gnt_o,
   output logic                 dr_rvalid_o,
   output logic [31:0]          dr_rdata_o,
   // store write port
   input  logic                 dw_req_i,
   input  logic [31:0]          dw_addr_i,
   input  logic [31:0]          dw_wdata_i,
   input  logic [3:0]           dw_wmask_i,
   output logic                 dw_gnt_o,
   // pipeline stall
   output logic                 busy_o,
   // backing RAM
   output logic                 mem_en_o,
   output logic [3:0]           mem_we_o,
   output logic [ADDR_BITS-1:0] mem_addr_o,
   output logic [31:0]          mem_wdata_o,
   input  logic [31:0]          mem_rdata_i
);

   localparam logic [2:0] LatCnt    = 3'(MEM_LATENCY);
   localparam logic [3:0] StarveTop = 4'(STARVE_MAX);

   typedef enum logic [0:0] {StIdle, StReadWait} state_e;
   typedef enum logic [0:0] {OwnLoad, OwnFetch} owner_e;

   state_e     state_q, state_d;
   owner_e     owner_q, owner_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] starve_q, starve_d;
   logic       kill_q, kill_d;
   logic       boost;

   // Byte-offset and out-of-range address bits are dropped, so addresses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{f_addr_i[31:ADDR_BITS+2], f_addr_i[1:0],
                               dr_addr_i[31:ADDR_BITS+2], dr_addr_i[1:0],
                               dw_addr_i[31:ADDR_BITS+2], dw_addr_i[1:0]};

   // State register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         owner_q  <= OwnLoad;
         cnt_q    <= '0;
         starve_q <= '0;
         kill_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         kill_q   <= kill_d;
      end
   end

   // Arbitration, read-latency tracking and all outputs; everything is held
   // quiet while reset is asserted.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      kill_d      = kill_q;
      starve_d    = starve_q;
      boost       = (starve_q == StarveTop);
      f_gnt_o     = 1'b0;
      f_rvalid_o  = 1'b0;
      f_rdata_o   = '0;
      dr_gnt_o    = 1'b0;
      dr_rvalid_o = 1'b0;
      dr_rdata_o  = '0;
      dw_gnt_o    = 1'b0;
      busy_o      = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;

      if (!reset_i) begin
         unique case (state_q)
            StIdle: begin
               if (f_req_i && boost) begin
                  f_gnt_o = 1'b1;
               end else if (dw_req_i) begin
                  dw_gnt_o = 1'b1;
               end else if (dr_req_i) begin
                  dr_gnt_o = 1'b1;
               end else if (f_req_i) begin
                  f_gnt_o = 1'b1;
               end

               if (dw_gnt_o) begin
                  mem_en_o    = 1'b1;
                  mem_we_o    = dw_wmask_i;
                  mem_addr_o  = dw_addr_i[ADDR_BITS+1:2];
                  mem_wdata_o = dw_wdata_i;
               end else if (dr_gnt_o) begin
                  mem_en_o   = 1'b1;
                  mem_addr_o = dr_addr_i[ADDR_BITS+1:2];
                  state_d    = StReadWait;
                  owner_d    = OwnLoad;
                  cnt_d      = 3'd1;
                  kill_d     = 1'b0;
               end else if (f_gnt_o) begin
                  mem_en_o   = 1'b1;
                  mem_addr_o = f_addr_i[ADDR_BITS+1:2];
                  state_d    = StReadWait;
                  owner_d    = OwnFetch;
                  cnt_d      = 3'd1;
                  // A flush in the grant cycle already invalidates this fetch.
                  kill_d     = f_kill_i;
               end
            end
            StReadWait: begin
               busy_o = 1'b1;
               if (owner_q == OwnFetch && f_kill_i) begin
                  kill_d = 1'b1;
               end
               if (cnt_q == LatCnt) begin
                  state_d = StIdle;
                  kill_d  = 1'b0;
                  if (owner_q == OwnFetch) begin
                     if (!(kill_q || f_kill_i)) begin
                        f_rvalid_o = 1'b1;
                        f_rdata_o  = mem_rdata_i;
                     end
                  end else begin
                     dr_rvalid_o = 1'b1;
                     dr_rdata_o  = mem_rdata_i;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            default: state_d = StIdle;
         endcase

         // Count consecutive denied fetch cycles, saturating at the boost level.
         if (!f_req_i || f_gnt_o) begin
            starve_d = '0;
         end else if (starve_q < StarveTop) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

endmodule
